// File: rtl/muldiv_sched_if.sv
`timescale 1ns/1ps
// muldiv_sched_if
// Groups every signal that passes between the HI/LO mul/div scheduler and its
// surroundings: the two issue-pipe requests, the EXE flush, the shared
// multiplier, the iterative divider, the stall request and the HI/LO write port.
//   slave  : the scheduler side (takes requests and unit results, drives
//            operands, stall and writeback)
//   master : the environment side (issue pipes, multiplier, divider, HI/LO)
// clk/reset are plain ports of the scheduler and are not part of this bundle.
interface muldiv_sched_if;
  logic        req0_valid;
  logic        req0_div;
  logic        req0_signed;
  logic [31:0] req0_src1;
  logic [31:0] req0_src2;
  logic        req1_valid;
  logic        req1_div;
  logic        req1_signed;
  logic [31:0] req1_src1;
  logic [31:0] req1_src2;
  logic        flush;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic        div_start;
  logic        div_signed;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_end;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        stallreq_exe;
  logic        hilo_we;
  logic [63:0] hilo_wdata;
  logic        hilo_owner;
  logic        div_by_zero;

  modport slave (
    input  req0_valid, req0_div, req0_signed, req0_src1, req0_src2,
    input  req1_valid, req1_div, req1_signed, req1_src1, req1_src2,
    input  flush,
    output mul_a, mul_b, mul_signed,
    input  mul_result,
    output div_start, div_signed, div_dividend, div_divisor,
    input  div_end, div_quotient, div_remainder,
    output stallreq_exe, hilo_we, hilo_wdata, hilo_owner, div_by_zero
  );

  modport master (
    output req0_valid, req0_div, req0_signed, req0_src1, req0_src2,
    output req1_valid, req1_div, req1_signed, req1_src1, req1_src2,
    output flush,
    input  mul_a, mul_b, mul_signed,
    output mul_result,
    input  div_start, div_signed, div_dividend, div_divisor,
    output div_end, div_quotient, div_remainder,
    input  stallreq_exe, hilo_we, hilo_wdata, hilo_owner, div_by_zero
  );
endinterface

// File: rtl/muldiv_sched.sv
`timescale 1ns/1ps
// muldiv_sched
// Sequences the single shared HI/LO multiply/divide resource between the two
// issue pipes of the dual-issue EXE stage. Pipe0 (older) has priority over
// pipe1 (younger); one op runs at a time, and each finished op produces one
// HI/LO write pulse tagged with the pipe that owns it. The EXE stall request
// stays up until every issued op in the bundle has written back.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-high reset
//   bus    : muldiv_sched_if.slave (requests, flush, multiplier, divider,
//            stall request, HI/LO write port)
// Parameters:
//   MUL_LAT: cycles the multiplier needs from stable operands to a valid
//            product (1..7)
module muldiv_sched #(
  parameter int MUL_LAT = 2
) (
  input logic           clk,
  input logic           reset,
  muldiv_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q;
  logic        done0_q;
  logic        done1_q;
  logic        owner_q;
  logic        signed_q;
  logic [31:0] opA_q;
  logic [31:0] opB_q;
  logic [2:0]  cnt_q;
  logic        divStart_q;
  logic        hiloWe_q;
  logic        hiloOwner_q;
  logic [63:0] hiloWdata_q;
  logic        divByZero_q;

  logic        pend0;
  logic        pend1;
  logic        otherPend;
  logic        stall;
  logic        grantValid;
  logic        grantPipe;
  logic        grantDiv;
  logic        grantSigned;
  logic [31:0] grantSrc1;
  logic [31:0] grantSrc2;

  // A pipe is still waiting while its op is valid and has not yet written
  // back during this stall. In DONE, the pipe other than the owner decides
  // whether the stall can be released in the writeback cycle itself.
  // Reset and flush force the stall low so the pipeline is never held by an
  // op that is being thrown away.
  always_comb begin
    pend0     = bus.req0_valid & ~done0_q;
    pend1     = bus.req1_valid & ~done1_q;
    otherPend = owner_q ? pend0 : pend1;
    stall     = ~reset & ~bus.flush & (pend0 | pend1) &
                ~((state_q == DONE) & ~otherPend);
  end

  // Fixed-priority pick of the next op: the older pipe0 always goes first,
  // so a dual mul/div bundle retires in program order.
  always_comb begin
    grantValid  = pend0 | pend1;
    grantPipe   = ~pend0;
    grantDiv    = bus.req0_div;
    grantSigned = bus.req0_signed;
    grantSrc1   = bus.req0_src1;
    grantSrc2   = bus.req0_src2;
    if (!pend0) begin
      grantDiv    = bus.req1_div;
      grantSigned = bus.req1_signed;
      grantSrc1   = bus.req1_src1;
      grantSrc2   = bus.req1_src2;
    end
  end

  // Main sequencer. The writeback pulse, its owner tag and the divide-by-zero
  // qualifier default low every cycle and are only raised on the transition
  // into DONE, so they are high for exactly the DONE cycle. A zero divisor
  // never starts the divider: the fixed {dividend, all-ones} result is
  // written straight away. Done flags drop as soon as the stall releases,
  // because the pipeline then advances and the next bundle starts fresh.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      owner_q     <= 1'b0;
      signed_q    <= 1'b0;
      opA_q       <= 32'd0;
      opB_q       <= 32'd0;
      cnt_q       <= 3'd0;
      divStart_q  <= 1'b0;
      hiloWe_q    <= 1'b0;
      hiloOwner_q <= 1'b0;
      hiloWdata_q <= 64'd0;
      divByZero_q <= 1'b0;
    end else begin
      hiloWe_q    <= 1'b0;
      hiloOwner_q <= 1'b0;
      divByZero_q <= 1'b0;
      if (bus.flush) begin
        state_q    <= IDLE;
        done0_q    <= 1'b0;
        done1_q    <= 1'b0;
        divStart_q <= 1'b0;
      end else begin
        if (!stall) begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
        end else if (state_q == DONE) begin
          if (owner_q) begin
            done1_q <= 1'b1;
          end else begin
            done0_q <= 1'b1;
          end
        end

        unique case (state_q)
          IDLE: begin
            if (grantValid) begin
              owner_q  <= grantPipe;
              signed_q <= grantSigned;
              opA_q    <= grantSrc1;
              opB_q    <= grantSrc2;
              if (grantDiv && (grantSrc2 == 32'd0)) begin
                hiloWdata_q <= {grantSrc1, 32'hFFFF_FFFF};
                divByZero_q <= 1'b1;
                hiloWe_q    <= 1'b1;
                hiloOwner_q <= grantPipe;
                state_q     <= DONE;
              end else if (grantDiv) begin
                divStart_q <= 1'b1;
                state_q    <= DIV;
              end else begin
                cnt_q   <= 3'(MUL_LAT - 1);
                state_q <= MUL;
              end
            end
          end
          MUL: begin
            if (cnt_q == 3'd0) begin
              hiloWdata_q <= bus.mul_result;
              hiloWe_q    <= 1'b1;
              hiloOwner_q <= owner_q;
              state_q     <= DONE;
            end else begin
              cnt_q <= cnt_q - 3'd1;
            end
          end
          DIV: begin
            if (bus.div_end) begin
              hiloWdata_q <= {bus.div_remainder, bus.div_quotient};
              hiloWe_q    <= 1'b1;
              hiloOwner_q <= owner_q;
              divStart_q  <= 1'b0;
              state_q     <= DONE;
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // Unit operands come only from the latched copy of the granted op, so the
  // multiplier and divider see stable inputs while the pipes stay stalled.
  assign bus.mul_a        = opA_q;
  assign bus.mul_b        = opB_q;
  assign bus.mul_signed   = signed_q;
  assign bus.div_dividend = opA_q;
  assign bus.div_divisor  = opB_q;
  assign bus.div_signed   = signed_q;
  assign bus.div_start    = divStart_q;
  assign bus.stallreq_exe = stall;
  assign bus.hilo_we      = hiloWe_q;
  assign bus.hilo_owner   = hiloOwner_q;
  assign bus.hilo_wdata   = hiloWdata_q;
  assign bus.div_by_zero  = divByZero_q;

endmodule

// File: tb/tb_muldiv_sched.sv
`timescale 1ns/1ps
// tb_muldiv_sched
// Directed bench for muldiv_sched with MUL_LAT=2. The bench plays the issue
// pipes, a combinational multiplier and a scripted divider, and compares the
// scheduler outputs against hand-computed constants.
module tb_muldiv_sched;

  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;

  muldiv_sched_if bus ();

  muldiv_sched #(.MUL_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Stand-in for the shared multiplier: product of whatever operands the
  // scheduler presents, honouring signedness.
  logic signed [63:0] mulSa;
  logic signed [63:0] mulSb;
  always_comb begin
    mulSa = {{32{bus.mul_a[31]}}, bus.mul_a};
    mulSb = {{32{bus.mul_b[31]}}, bus.mul_b};
    if (bus.mul_signed) begin
      bus.mul_result = mulSa * mulSb;
    end else begin
      bus.mul_result = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
    end
  end

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one pipe's request fields.
  task automatic applyStimulus(input bit pipe, input bit valid, input bit isDiv,
                               input bit isSigned, input logic [31:0] src1,
                               input logic [31:0] src2);
    if (!pipe) begin
      bus.req0_valid  = valid;
      bus.req0_div    = isDiv;
      bus.req0_signed = isSigned;
      bus.req0_src1   = src1;
      bus.req0_src2   = src2;
    end else begin
      bus.req1_valid  = valid;
      bus.req1_div    = isDiv;
      bus.req1_signed = isSigned;
      bus.req1_src1   = src1;
      bus.req1_src2   = src2;
    end
  endtask

  task automatic clearInputs();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    bus.flush         = 1'b0;
    bus.div_end       = 1'b0;
    bus.div_quotient  = 32'd0;
    bus.div_remainder = 32'd0;
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lowCount;
    int weCount;

    clearInputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_stall", 64'(bus.stallreq_exe), 64'd0);
    checkOutput("rst_hilo_we", 64'(bus.hilo_we), 64'd0);
    checkOutput("rst_wdata", bus.hilo_wdata, 64'd0);
    checkOutput("rst_div_start", 64'(bus.div_start), 64'd0);
    checkOutput("rst_mul_a", 64'(bus.mul_a), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // MULT pipe0: -2 * 3, request in cycle T, write in T+3
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3);
    #1;
    checkOutput("mul_stall_T", 64'(bus.stallreq_exe), 64'd1);
    nextCycle();
    checkOutput("mul_a", 64'(bus.mul_a), 64'hFFFF_FFFE);
    checkOutput("mul_b", 64'(bus.mul_b), 64'd3);
    checkOutput("mul_signed", 64'(bus.mul_signed), 64'd1);
    checkOutput("mul_stall_T1", 64'(bus.stallreq_exe), 64'd1);
    nextCycle();
    checkOutput("mul_stall_T2", 64'(bus.stallreq_exe), 64'd1);
    checkOutput("mul_we_T2", 64'(bus.hilo_we), 64'd0);
    nextCycle();
    checkOutput("mul_we_T3", 64'(bus.hilo_we), 64'd1);
    checkOutput("mul_wdata", bus.hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFA);
    checkOutput("mul_owner", 64'(bus.hilo_owner), 64'd0);
    checkOutput("mul_dbz", 64'(bus.div_by_zero), 64'd0);
    checkOutput("mul_stall_T3", 64'(bus.stallreq_exe), 64'd0);
    nextCycle();
    clearInputs();
    #1;
    checkOutput("mul_we_T4", 64'(bus.hilo_we), 64'd0);

    // DIVU pipe1: 100/7, div_end 33 cycles after accept
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd100, 32'd7);
    #1;
    checkOutput("divu_stall_A", 64'(bus.stallreq_exe), 64'd1);
    lowCount = 0;
    weCount = 0;
    for (int i = 1; i <= 32; i++) begin
      nextCycle();
      if (bus.div_start !== 1'b1) lowCount++;
      if (bus.hilo_we !== 1'b0) weCount++;
    end
    checkOutput("divu_start_held", 64'(lowCount), 64'd0);
    checkOutput("divu_no_early_we", 64'(weCount), 64'd0);
    checkOutput("divu_dividend", 64'(bus.div_dividend), 64'd100);
    checkOutput("divu_divisor", 64'(bus.div_divisor), 64'd7);
    checkOutput("divu_signed", 64'(bus.div_signed), 64'd0);
    nextCycle();
    bus.div_end       = 1'b1;
    bus.div_quotient  = 32'd14;
    bus.div_remainder = 32'd2;
    #1;
    checkOutput("divu_start_E", 64'(bus.div_start), 64'd1);
    nextCycle();
    bus.div_end = 1'b0;
    #1;
    checkOutput("divu_we", 64'(bus.hilo_we), 64'd1);
    checkOutput("divu_wdata", bus.hilo_wdata, {32'd2, 32'd14});
    checkOutput("divu_owner", 64'(bus.hilo_owner), 64'd1);
    checkOutput("divu_start_done", 64'(bus.div_start), 64'd0);
    checkOutput("divu_stall_done", 64'(bus.stallreq_exe), 64'd0);
    nextCycle();
    clearInputs();

    // Dual bundle: pipe0 MULTU 5*6, pipe1 DIV -9/2
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd6);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF7, 32'd2);
    nextCycle();
    nextCycle();
    nextCycle();
    checkOutput("dual_we0", 64'(bus.hilo_we), 64'd1);
    checkOutput("dual_wdata0", bus.hilo_wdata, 64'd30);
    checkOutput("dual_owner0", 64'(bus.hilo_owner), 64'd0);
    checkOutput("dual_stall_done0", 64'(bus.stallreq_exe), 64'd1);
    nextCycle();
    checkOutput("dual_stall_idle", 64'(bus.stallreq_exe), 64'd1);
    checkOutput("dual_we_idle", 64'(bus.hilo_we), 64'd0);
    nextCycle();
    checkOutput("dual_div_start", 64'(bus.div_start), 64'd1);
    checkOutput("dual_dividend", 64'(bus.div_dividend), 64'hFFFF_FFF7);
    checkOutput("dual_div_signed", 64'(bus.div_signed), 64'd1);
    nextCycle();
    bus.div_end       = 1'b1;
    bus.div_quotient  = 32'hFFFF_FFFC;
    bus.div_remainder = 32'hFFFF_FFFF;
    nextCycle();
    bus.div_end = 1'b0;
    #1;
    checkOutput("dual_we1", 64'(bus.hilo_we), 64'd1);
    checkOutput("dual_wdata1", bus.hilo_wdata, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("dual_owner1", 64'(bus.hilo_owner), 64'd1);
    checkOutput("dual_stall_done1", 64'(bus.stallreq_exe), 64'd0);
    nextCycle();
    clearInputs();
    #1;
    checkOutput("dual_we_after", 64'(bus.hilo_we), 64'd0);

    // DIV by zero on pipe0
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h1234, 32'd0);
    nextCycle();
    checkOutput("dbz_we", 64'(bus.hilo_we), 64'd1);
    checkOutput("dbz_flag", 64'(bus.div_by_zero), 64'd1);
    checkOutput("dbz_wdata", bus.hilo_wdata, 64'h0000_1234_FFFF_FFFF);
    checkOutput("dbz_div_start", 64'(bus.div_start), 64'd0);
    checkOutput("dbz_stall", 64'(bus.stallreq_exe), 64'd0);
    nextCycle();
    clearInputs();
    #1;
    checkOutput("dbz_flag_clear", 64'(bus.div_by_zero), 64'd0);

    // Flush in the 5th DIV cycle together with div_end
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd50, 32'd5);
    repeat (5) nextCycle();
    bus.flush         = 1'b1;
    bus.div_end       = 1'b1;
    bus.div_quotient  = 32'd10;
    bus.div_remainder = 32'd0;
    #1;
    checkOutput("flush_stall", 64'(bus.stallreq_exe), 64'd0);
    nextCycle();
    clearInputs();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd7, 32'd8);
    #1;
    checkOutput("flush_we", 64'(bus.hilo_we), 64'd0);
    checkOutput("flush_div_start", 64'(bus.div_start), 64'd0);
    checkOutput("flush_new_stall", 64'(bus.stallreq_exe), 64'd1);
    nextCycle();
    checkOutput("flush_we_next", 64'(bus.hilo_we), 64'd0);
    nextCycle();
    nextCycle();
    checkOutput("flush_mul_we", 64'(bus.hilo_we), 64'd1);
    checkOutput("flush_mul_wdata", bus.hilo_wdata, 64'd56);
    nextCycle();
    clearInputs();

    // Reset mid-MUL, then a fresh MULT with normal latency
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'd3, 32'd4);
    nextCycle();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rstmid_mul_a", 64'(bus.mul_a), 64'd0);
    checkOutput("rstmid_wdata", bus.hilo_wdata, 64'd0);
    checkOutput("rstmid_stall", 64'(bus.stallreq_exe), 64'd0);
    checkOutput("rstmid_we", 64'(bus.hilo_we), 64'd0);
    clearInputs();
    @(posedge clk);
    #3;
    reset = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h20);
    #1;
    checkOutput("post_rst_stall", 64'(bus.stallreq_exe), 64'd1);
    nextCycle();
    nextCycle();
    checkOutput("post_rst_we_T2", 64'(bus.hilo_we), 64'd0);
    nextCycle();
    checkOutput("post_rst_we_T3", 64'(bus.hilo_we), 64'd1);
    checkOutput("post_rst_wdata", bus.hilo_wdata, 64'h200);
    nextCycle();
    clearInputs();
    nextCycle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
